// File: rtl/cpu_pkg.sv
// cpu_pkg: shared CPU constants, fetch state encoding and pipeline widths
package cpu_pkg;
  localparam int INST_W = 32;
  localparam int ROM_WORDS = 64;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] NOP = 32'h0000_0000;
  typedef enum logic [1:0] {
    FS_BOOT = 2'd0,
    FS_RUN  = 2'd1,
    FS_HALT = 2'd2
  } fetch_state_t;
endpackage

// File: rtl/if_id_reg.sv
// if_id_reg: IF/ID pipeline register with load, valid-clear and instruction-zero controls
module if_id_reg
  import cpu_pkg::*;
#(
  parameter int W = INST_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_load,
  input  logic         i_clear,
  input  logic         i_zero,
  input  logic [W-1:0] i_inst,
  input  logic [W-1:0] i_pc4,
  output logic [W-1:0] o_inst,
  output logic [W-1:0] o_pc4,
  output logic         o_valid
);
  always_ff @(posedge clk) begin
    if (rst) begin
      o_inst  <= '0;
      o_pc4   <= '0;
      o_valid <= 1'b0;
    end else if (i_load) begin
      o_inst  <= i_inst;
      o_pc4   <= i_pc4;
      o_valid <= 1'b1;
    end else begin
      if (i_clear) o_valid <= 1'b0;
      if (i_zero) o_inst <= '0;
    end
  end
endmodule

// File: rtl/inst_fetch_ctrl.sv
// inst_fetch_ctrl: PC sequencer and IF/ID capture with stall, branch redirect and halt
module inst_fetch_ctrl #(
  parameter logic [31:0] RESET_PC = cpu_pkg::RESET_PC,
  parameter int          CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_stall,
  input  logic             i_branch_taken,
  input  logic [31:0]      i_branch_target,
  input  logic             i_halt_req,
  output logic [31:0]      o_rom_addr,
  input  logic [31:0]      i_rom_inst,
  output logic [31:0]      o_if_inst,
  output logic [31:0]      o_if_pc4,
  output logic             o_if_valid,
  output logic             o_halted,
  output logic [CNT_W-1:0] o_fetch_count
);
  import cpu_pkg::*;
  fetch_state_t      r_state, w_next;
  logic [31:0]       r_pc, w_pc_next, w_pc4;
  logic [CNT_W-1:0]  r_cnt;
  logic              w_load, w_clear, w_zero;
  assign w_pc4 = r_pc + 32'd4;
  assign o_rom_addr = r_pc & ~32'd3;
  assign o_halted = (r_state == FS_HALT);
  assign o_fetch_count = r_cnt;
  always_comb begin
    w_next    = r_state;
    w_pc_next = r_pc;
    w_load    = 1'b0;
    w_clear   = 1'b0;
    w_zero    = 1'b0;
    case (r_state)
      FS_BOOT: begin
        w_clear = 1'b1;
        w_next  = i_halt_req ? FS_HALT : FS_RUN;
      end
      FS_RUN: begin
        if (i_halt_req) begin
          w_clear = 1'b1;
          w_zero  = 1'b1;
          w_next  = FS_HALT;
        end else if (i_branch_taken) begin
          // redirect flushes the wrong-path fetch; stall is ignored this cycle
          w_clear   = 1'b1;
          w_zero    = 1'b1;
          w_pc_next = i_branch_target & ~32'd3;
        end else if (!i_stall) begin
          w_load    = 1'b1;
          w_pc_next = w_pc4;
        end
      end
      FS_HALT: w_clear = 1'b1;
      default: w_next = FS_BOOT;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= FS_BOOT;
      r_pc    <= RESET_PC;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next;
      r_pc    <= w_pc_next;
      if (w_load && !(&r_cnt)) r_cnt <= r_cnt + CNT_W'(1);
    end
  end
  if_id_reg #(.W(INST_W)) u_if_id (
    .clk     (clk),
    .rst     (rst),
    .i_load  (w_load),
    .i_clear (w_clear),
    .i_zero  (w_zero),
    .i_inst  (i_rom_inst),
    .i_pc4   (w_pc4),
    .o_inst  (o_if_inst),
    .o_pc4   (o_if_pc4),
    .o_valid (o_if_valid)
  );
endmodule

// File: tb/tb_inst_fetch_ctrl.sv
// tb_inst_fetch_ctrl: directed checks of fetch sequencing, stall, branch, halt, aliasing and counter saturation
module tb_inst_fetch_ctrl;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall = 1'b0;
  logic        br = 1'b0;
  logic [31:0] tgt = '0;
  logic        halt = 1'b0;
  logic [31:0] rom_addr, rom_inst, if_inst, if_pc4;
  logic        if_valid, halted;
  logic [15:0] cnt;
  logic [31:0] rom [64];
  int n_err = 0;
  int n_chk = 0;
  always #5 clk = ~clk;
  assign rom_inst = rom[rom_addr[7:2]];
  inst_fetch_ctrl dut (
    .clk             (clk),
    .rst             (rst),
    .i_stall         (stall),
    .i_branch_taken  (br),
    .i_branch_target (tgt),
    .i_halt_req      (halt),
    .o_rom_addr      (rom_addr),
    .i_rom_inst      (rom_inst),
    .o_if_inst       (if_inst),
    .o_if_pc4        (if_pc4),
    .o_if_valid      (if_valid),
    .o_halted        (halted),
    .o_fetch_count   (cnt)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
    step();
  endtask
  initial begin
    for (int i = 0; i < 64; i++) rom[i] = 32'hA000_0000 | 32'(i);
    rom[0] = 32'h3c001000;
    rom[1] = 32'h14003c01;
    rom[2] = 32'h14005002;
    rom[3] = 32'h00000000;
    step();
    step();
    chk("rst_addr", rom_addr, 32'h0);
    chk("rst_inst", if_inst, 32'h0);
    chk("rst_pc4", if_pc4, 32'h0);
    chk("rst_valid", 32'(if_valid), 32'h0);
    chk("rst_halted", 32'(halted), 32'h0);
    chk("rst_cnt", 32'(cnt), 32'h0);
    rst = 1'b0;
    step();
    chk("boot_valid", 32'(if_valid), 32'h0);
    chk("boot_addr", rom_addr, 32'h0);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("seq_inst", if_inst, rom[i]);
      chk("seq_pc4", if_pc4, 32'(4 * (i + 1)));
      chk("seq_valid", 32'(if_valid), 32'h1);
    end
    chk("seq_cnt", 32'(cnt), 32'd4);
    do_reset();
    step();
    step();
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stall_addr", rom_addr, 32'h8);
      chk("stall_inst", if_inst, 32'h14003c01);
      chk("stall_pc4", if_pc4, 32'h8);
      chk("stall_valid", 32'(if_valid), 32'h1);
    end
    chk("stall_cnt", 32'(cnt), 32'd2);
    stall = 1'b0;
    step();
    chk("unstall_inst", if_inst, 32'h14005002);
    chk("unstall_pc4", if_pc4, 32'hC);
    do_reset();
    step();
    br = 1'b1;
    tgt = 32'h12;
    step();
    br = 1'b0;
    chk("br_valid", 32'(if_valid), 32'h0);
    chk("br_inst", if_inst, 32'h0);
    chk("br_addr", rom_addr, 32'h10);
    chk("br_pc4_held", if_pc4, 32'h4);
    step();
    chk("br_tgt_inst", if_inst, rom[4]);
    chk("br_tgt_pc4", if_pc4, 32'h14);
    chk("br_tgt_valid", 32'(if_valid), 32'h1);
    br = 1'b1;
    stall = 1'b1;
    tgt = 32'h20;
    step();
    br = 1'b0;
    stall = 1'b0;
    chk("brst_addr", rom_addr, 32'h20);
    chk("brst_valid", 32'(if_valid), 32'h0);
    step();
    chk("brst_inst", if_inst, rom[8]);
    chk("brst_pc4", if_pc4, 32'h24);
    do_reset();
    step();
    step();
    step();
    chk("pre_halt_addr", rom_addr, 32'hC);
    halt = 1'b1;
    step();
    halt = 1'b0;
    chk("halt_flag", 32'(halted), 32'h1);
    chk("halt_valid", 32'(if_valid), 32'h0);
    repeat (5) step();
    chk("halt_hold_flag", 32'(halted), 32'h1);
    chk("halt_hold_valid", 32'(if_valid), 32'h0);
    chk("halt_hold_addr", rom_addr, 32'hC);
    chk("halt_hold_cnt", 32'(cnt), 32'd3);
    chk("halt_hold_inst", if_inst, 32'h0);
    rst = 1'b1;
    step();
    chk("halt_rst_flag", 32'(halted), 32'h0);
    chk("halt_rst_addr", rom_addr, 32'h0);
    rst = 1'b0;
    halt = 1'b1;
    step();
    halt = 1'b0;
    chk("boot_halt_flag", 32'(halted), 32'h1);
    step();
    chk("boot_halt_addr", rom_addr, 32'h0);
    chk("boot_halt_valid", 32'(if_valid), 32'h0);
    do_reset();
    br = 1'b1;
    tgt = 32'hFC;
    step();
    br = 1'b0;
    step();
    chk("alias_w63", if_inst, rom[63]);
    chk("alias_pc4a", if_pc4, 32'h100);
    chk("alias_addr", rom_addr, 32'h100);
    step();
    chk("alias_w0", if_inst, rom[0]);
    chk("alias_pc4b", if_pc4, 32'h104);
    do_reset();
    repeat (65534) step();
    chk("sat_pre", 32'(cnt), 32'hFFFE);
    repeat (3) step();
    chk("sat_cnt", 32'(cnt), 32'hFFFF);
    chk("sat_valid", 32'(if_valid), 32'h1);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/inst_fetch_ctrl.md
Name: inst_fetch_ctrl

Overview:
- Instruction-fetch sequencer for the pipelined CPU.
- Owns the program counter and drives the word-addressed instruction ROM address.
- Captures the returned instruction into the IF/ID pipeline register.
- Applies stall, branch redirect and halt requests from the hazard/branch logic.
- Sits between the hazard unit, the EX-stage branch resolver, the instruction ROM and the ID stage.

Parameters:
RESET_PC, 32'h00000000, PC value loaded on reset
ROM_WORDS, 64, ROM depth in words; the ROM uses address bits [7:2]
CNT_W, 16, width of the delivered-instruction counter

Ports:
clk  in  1  system clock, all state updates on rising edge
rst  in  1  synchronous active-high reset
stall  in  1  hazard unit: hold PC and IF/ID contents
branch_taken  in  1  EX stage: redirect fetch this cycle
branch_target  in  32  redirect byte address
halt_req  in  1  stop fetching until next reset
rom_addr  out  32  byte address to instruction ROM (combinational from PC)
rom_inst  in  32  instruction word returned combinationally by ROM
if_inst  out  32  IF/ID instruction register
if_pc4  out  32  IF/ID PC+4 register
if_valid  out  1  IF/ID contents are a real instruction (0 = bubble)
halted  out  1  block is in HALT
fetch_count  out  CNT_W  instructions delivered to ID, saturating

Behaviour:
- Reset (rst=1 at clk edge) values:
  - pc=RESET_PC, state=BOOT.
  - if_inst=0, if_pc4=0, if_valid=0, halted=0, fetch_count=0.
  - rst overrides every other input.
- rom_addr = {pc[31:2],2'b00}, combinational, with zero latency to rom_inst.
- States: BOOT, RUN, HALT.
  - BOOT: lasts one cycle. if_valid<=0, pc unchanged. Next state is RUN; goes to HALT if halt_req=1.
  - RUN: each edge is resolved in strict priority order, first match wins:
    1. halt_req: if_valid<=0, if_inst<=0, pc held, state<=HALT.
    2. branch_taken: pc<={branch_target[31:2],2'b00}; if_valid<=0, if_inst<=0 (flush the wrong-path fetch); if_pc4 held.
    3. stall: pc, if_inst, if_pc4, if_valid all held.
    4. Otherwise: if_inst<=rom_inst, if_pc4<=pc+4, if_valid<=1, pc<=pc+4.
  - Branch and stall asserted together: the branch wins, and the stall is ignored for that cycle.
  - HALT: all registers held except if_valid, which is forced to 0. halted=1. Only rst exits.
- Latency: the instruction at pc appears on if_inst one edge after it is addressed, assuming no stall or branch.
- A redirect costs exactly one bubble: the target instruction is valid on the second edge after branch_taken.
- PC arithmetic is 32-bit modulo 2^32.
  - PC values at or beyond ROM_WORDS*4 are not trapped; the ROM aliases via bits [7:2].
  - Example: pc=0x100 reads ROM word 0.
- branch_target low 2 bits are discarded silently.
- fetch_count increments on every edge in which if_valid is loaded with 1. It saturates at all-ones.
- Encoding 32'h00000000 is treated as an ordinary instruction (nop); it is not a halt.

Decomposition:
- Shared package cpu_pkg holds:
  - Fetch state encoding FS_BOOT=2'd0, FS_RUN=2'd1, FS_HALT=2'd2.
  - The instruction width (32).
  - RESET_PC.
  - The NOP encoding 32'h00000000.
- One natural sub-module, if_id_reg: the IF/ID register with load-enable and clear inputs. It is reused by later pipeline registers.
- PC, FSM and counter stay in the top block.

Test Plan:
- Reset, then run 4 cycles with ROM words 0..3 = 3c001000, 14003c01, 14005002, 0 and no stall or branch.
  - After BOOT: if_inst sequence 3c001000, 14003c01, 14005002, 00000000.
  - if_pc4 sequence 4, 8, C, 10. fetch_count=4.
- In RUN at pc=8, assert stall for 3 cycles.
  - pc stays 8 and the IF/ID registers are frozen.
  - On release, the next if_inst = word 2 with if_pc4=C.
- branch_taken=1, branch_target=0x12 while pc=4.
  - Next edge: if_valid=0, if_inst=0, pc=0x10.
  - Following edge: if_inst=ROM word 4, if_pc4=0x14, if_valid=1.
- branch_taken=1 and stall=1 in the same cycle with target 0x20.
  - pc becomes 0x20 and if_valid=0 (branch wins).
- halt_req pulse at pc=0xC.
  - halted=1, if_valid=0 indefinitely, pc stays 0xC, fetch_count frozen.
  - rst then returns to pc=0 and BOOT.
- Run from pc=0xFC with no branch.
  - Fetch of word 63 is followed by pc=0x100 with if_inst = ROM word 0 (alias), if_pc4=0x104.
- Pre-set fetch_count to 0xFFFE via run length (or force), then fetch 3 instructions.
  - fetch_count saturates at 0xFFFF.
